// File: rtl/i2c_pkg.sv
// Shared constants for the i2c_master command interface and the register-access sequencer.
package i2c_pkg;

    localparam int CB_STRT = 0;
    localparam int CB_STOP = 1;
    localparam int CB_READ = 2;
    localparam int CB_WRTE = 3;
    localparam int CB_NACK = 4;

    localparam logic [4:0] C_STRT = 5'b00001;
    localparam logic [4:0] C_STOP = 5'b00010;
    localparam logic [4:0] C_READ = 5'b00100;
    localparam logic [4:0] C_WRTE = 5'b01000;
    localparam logic [4:0] C_NACK = 5'b10000;
    localparam logic [4:0] C_CLRS = 5'b00000;

    localparam int SB_BSY = 0;
    localparam int SB_ERR = 1;
    localparam int SB_ALO = 2;
    localparam int SB_ACK = 3;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_ALO  = 2'd2;
    localparam logic [1:0] ERR_REJ  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CLR,
        ST_ISSUE,
        ST_ACPT,
        ST_WAIT,
        ST_CHECK,
        ST_STOP,
        ST_STOPW,
        ST_RESP
    } state_t;

endpackage

// File: rtl/i2c_reg_seq_step.sv
// Step table: maps the current step of a register access to the i2c_master command and data byte.
module i2c_reg_seq_step
    import i2c_pkg::*;
(
    input  logic [1:0] step_i,
    input  logic       rnw_i,
    input  logic [6:0] dev_i,
    input  logic [7:0] reg_i,
    input  logic [7:0] wdat_i,
    output logic [4:0] cmd_o,
    output logic [7:0] dat_o,
    output logic       is_last_o,
    output logic       has_stop_o
);

    always_comb begin
        cmd_o      = C_CLRS;
        dat_o      = 8'h00;
        is_last_o  = 1'b0;
        has_stop_o = 1'b0;
        case (step_i)
            2'd0: begin
                cmd_o = C_STRT | C_WRTE;
                dat_o = {dev_i, 1'b0};
            end
            2'd1: begin
                cmd_o = C_WRTE;
                dat_o = reg_i;
            end
            2'd2: begin
                if (rnw_i) begin
                    // repeated START turning the bus around for the read phase
                    cmd_o = C_STRT | C_WRTE;
                    dat_o = {dev_i, 1'b1};
                end else begin
                    cmd_o      = C_WRTE | C_STOP;
                    dat_o      = wdat_i;
                    is_last_o  = 1'b1;
                    has_stop_o = 1'b1;
                end
            end
            default: begin
                cmd_o      = C_READ | C_NACK | C_STOP;
                dat_o      = 8'h00;
                is_last_o  = 1'b1;
                has_stop_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/i2c_reg_seq.sv
// Register-access sequencer: turns one read/write request into i2c_master byte commands,
// with ACK checking, STOP after NACK and bounded retry on arbitration loss.
//
// state  | meaning
// IDLE   | waiting for a request
// CLR    | master idle -> strobe clear-status
// ISSUE  | master idle -> strobe current step
// ACPT   | one cycle after strobe, check the master took it
// WAIT   | byte in progress
// CHECK  | evaluate ALO/ERR/ACK, advance, retry or finish
// STOP   | NACK mid-sequence, strobe STOP only
// STOPW  | wait for STOP to complete
// RESP   | one-cycle response pulse
module i2c_reg_seq
    import i2c_pkg::*;
#(
    parameter int RETRIES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_vld,
    output logic       req_rdy,
    input  logic       req_rnw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdat,
    output logic       rsp_vld,
    output logic [1:0] rsp_err,
    output logic [7:0] rsp_rdat,
    output logic [4:0] m_cmd,
    output logic [7:0] m_dat,
    output logic       m_ws,
    input  logic [3:0] m_stat,
    input  logic [7:0] m_rdat
);

    localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);

    state_t        state_q, state_d;
    logic [1:0]    step_q, step_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [1:0]    rsp_err_q, rsp_err_d;
    logic [7:0]    rsp_rdat_q, rsp_rdat_d;
    logic          req_rdy_q, req_rdy_d;
    logic          ws_q;
    logic [4:0]    m_cmd_q;
    logic [7:0]    m_dat_q;
    logic          rnw_q;
    logic [6:0]    dev_q;
    logic [7:0]    reg_q, wdat_q;

    logic       accept;
    logic       ws;
    logic [4:0] cmd, s_cmd;
    logic [7:0] dat, s_dat;
    logic       s_last, s_stop;
    logic       bsy, err, alo, ack;
    logic       rd_data_step;

    assign bsy = m_stat[SB_BSY];
    assign err = m_stat[SB_ERR];
    assign alo = m_stat[SB_ALO];
    assign ack = m_stat[SB_ACK];

    assign accept       = req_vld && req_rdy_q;
    assign rd_data_step = rnw_q && (step_q == 2'd3);

    i2c_reg_seq_step u_step (
        .step_i     (step_q),
        .rnw_i      (rnw_q),
        .dev_i      (dev_q),
        .reg_i      (reg_q),
        .wdat_i     (wdat_q),
        .cmd_o      (s_cmd),
        .dat_o      (s_dat),
        .is_last_o  (s_last),
        .has_stop_o (s_stop)
    );

    // Strobes are gated by ws_q so a clear that leaves the master idle is never followed
    // by a back-to-back command strobe.
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        retry_d    = retry_q;
        rsp_err_d  = rsp_err_q;
        rsp_rdat_d = rsp_rdat_q;
        ws         = 1'b0;
        cmd        = m_cmd_q;
        dat        = m_dat_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CLR;
                    step_d  = 2'd0;
                    retry_d = '0;
                end
            end
            ST_CLR: begin
                if (!bsy && !ws_q) begin
                    ws      = 1'b1;
                    cmd     = C_CLRS;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bsy && !ws_q) begin
                    ws      = 1'b1;
                    cmd     = s_cmd;
                    dat     = s_dat;
                    state_d = ST_ACPT;
                end
            end
            ST_ACPT: begin
                if (bsy) begin
                    state_d = ST_WAIT;
                end else if (err) begin
                    rsp_err_d = ERR_REJ;
                    state_d   = ST_RESP;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_WAIT: begin
                if (!bsy) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (alo) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        step_d  = 2'd0;
                        state_d = ST_CLR;
                    end else begin
                        rsp_err_d = ERR_ALO;
                        state_d   = ST_RESP;
                    end
                end else if (err) begin
                    rsp_err_d = ERR_REJ;
                    state_d   = ST_RESP;
                end else if (!rd_data_step && !ack) begin
                    if (s_stop) begin
                        rsp_err_d = ERR_NACK;
                        state_d   = ST_RESP;
                    end else begin
                        state_d = ST_STOP;
                    end
                end else if (s_last) begin
                    if (rd_data_step) rsp_rdat_d = m_rdat;
                    rsp_err_d = ERR_OK;
                    state_d   = ST_RESP;
                end else begin
                    step_d  = step_q + 2'd1;
                    state_d = ST_ISSUE;
                end
            end
            ST_STOP: begin
                if (!bsy && !ws_q) begin
                    ws      = 1'b1;
                    cmd     = C_STOP;
                    state_d = ST_STOPW;
                end
            end
            ST_STOPW: begin
                if (!ws_q && !bsy) begin
                    rsp_err_d = alo ? ERR_ALO : ERR_NACK;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_rdy_d = (state_d == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            step_q     <= 2'd0;
            retry_q    <= '0;
            rsp_err_q  <= ERR_OK;
            rsp_rdat_q <= 8'h00;
            req_rdy_q  <= 1'b0;
            ws_q       <= 1'b0;
            m_cmd_q    <= C_CLRS;
            m_dat_q    <= 8'h00;
            rnw_q      <= 1'b0;
            dev_q      <= 7'h00;
            reg_q      <= 8'h00;
            wdat_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            retry_q    <= retry_d;
            rsp_err_q  <= rsp_err_d;
            rsp_rdat_q <= rsp_rdat_d;
            req_rdy_q  <= req_rdy_d;
            ws_q       <= ws;
            m_cmd_q    <= cmd;
            m_dat_q    <= dat;
            if (accept) begin
                rnw_q  <= req_rnw;
                dev_q  <= req_dev;
                reg_q  <= req_reg;
                wdat_q <= req_wdat;
            end
        end
    end

    assign req_rdy  = req_rdy_q;
    assign rsp_vld  = (state_q == ST_RESP);
    assign rsp_err  = rsp_err_q;
    assign rsp_rdat = rsp_rdat_q;
    assign m_ws     = ws;
    assign m_cmd    = cmd;
    assign m_dat    = dat;

endmodule

// File: doc/i2c_reg_seq.md
Name: i2c_reg_seq

Overview:
- Upstream command sequencer for i2c_master.
- Turns one register-access request (7-bit device address, 8-bit register, 1 data byte, read or write) into the i2c_master byte-command sequence over its cmd/dat/ws/stat_out/dat_out interface.
- Handles ACK checking, bus release after NACK, and bounded retry on arbitration loss.
- Returns a single response pulse carrying read data and an error code.

Parameters:
- RETRIES, 2, number of re-attempts after arbitration loss before reporting failure (0 = no retry).

Ports:
- clk  in  1  system clock, shared with i2c_master.
- rst  in  1  synchronous active-high reset; the same net also resets i2c_master.
- req_vld  in  1  request valid.
- req_rdy  out  1  request accepted when req_vld && req_rdy at posedge clk.
- req_rnw  in  1  1 = register read, 0 = register write.
- req_dev  in  7  7-bit slave address.
- req_reg  in  8  register index.
- req_wdat  in  8  write data; ignored for reads.
- rsp_vld  out  1  one-cycle pulse: transaction finished.
- rsp_err  out  2  0 OK, 1 NACK, 2 arbitration lost (retries exhausted), 3 command rejected.
- rsp_rdat  out  8  read data, valid with rsp_vld && rsp_err==0 && read.
- m_cmd  out  5  to i2c_master cmd; bit0 STRT, bit1 STOP, bit2 READ, bit3 WRTE, bit4 NACK; 0 = clear status.
- m_dat  out  8  to i2c_master dat.
- m_ws  out  1  to i2c_master ws; one-cycle strobe.
- m_stat  in  4  from i2c_master stat_out; bit0 BSY, bit1 ERR, bit2 ALO, bit3 ACK.
- m_rdat  in  8  from i2c_master dat_out.

Behaviour:
- Reset values: req_rdy=0, rsp_vld=0, rsp_err=0, rsp_rdat=0, m_ws=0, m_cmd=0, m_dat=0. State=IDLE, step=0, retry count=0.
- Request capture: req_rdy=1 only in IDLE. On accept, all request fields are latched and the FSM goes to CLR.
- Step table (cmd / dat):
  - S0: STRT|WRTE / {dev,0}
  - S1: WRTE / reg
  - Write only, S2: WRTE|STOP / wdat (last step).
  - Read only, S2: STRT|WRTE / {dev,1}
  - Read only, S3: READ|NACK|STOP / 0 (last step).
- States:
  - IDLE: wait for a request.
  - CLR: wait for m_stat.BSY=0 (covers the master's post-reset init busy), then drive m_ws=1, m_cmd=0 for one cycle to clear sticky ERR/ALO/ACK; go to ISSUE.
  - ISSUE: wait for BSY=0; drive m_ws=1 with the current step's cmd/dat for exactly one cycle; go to ACPT.
  - ACPT: sample m_stat one cycle after the strobe.
    - BSY=1: go to WAIT.
    - BSY=0 and ERR=1: command rejected; go to RESP with err=3.
  - WAIT: stay until BSY=0, then go to CHECK.
  - CHECK:
    - ALO=1: the master is already idle. If retry count < RETRIES, increment it, set step=0, go to CLR. Otherwise go to RESP with err=2.
    - ERR=1 without ALO: err=3, go to RESP.
    - Write step (S0, S1, write S2, read S2) with ACK=0: this is a NACK. If the step carried STOP, go to RESP with err=1. Otherwise go to STOP.
    - Read S3: capture rsp_rdat<=m_rdat; ignore ACK (master sends NACK by design); err=0; go to RESP.
    - Otherwise: if this was the last step, err=0 and go to RESP; else step+1 and go to ISSUE.
  - STOP: wait for BSY=0; issue m_cmd=STOP only; go to STOPW.
  - STOPW: wait one cycle, then wait for BSY=0; go to RESP with err=1. If ALO is set here, report err=2 with no retry.
  - RESP: rsp_vld=1 for one cycle; go to IDLE.
- rsp_err and rsp_rdat hold their values until the next RESP.
- m_ws is never asserted while BSY=1 and never two cycles in a row. m_cmd/m_dat equal the strobed values during the strobe cycle and are don't-care otherwise (the implementation holds them).
- Retry count resets to 0 on each accepted request.
- req_vld outside IDLE is ignored; no queuing.
- rst asserted mid-transaction: synchronous return to reset values on the next edge, with no STOP generated. i2c_master is reset by the same net and releases the bus.
- Throughput: one transaction in flight; minimum turnaround IDLE→IDLE is bus-limited.

Decomposition:
- Shared package i2c_pkg holds:
  - command bit indices/masks CB_STRT..CB_NACK and C_CLRS;
  - status bit indices SB_BSY..SB_ACK;
  - rsp_err codes ERR_OK/ERR_NACK/ERR_ALO/ERR_REJ;
  - the FSM state encoding.
- One combinational sub-module, i2c_reg_seq_step: (step, rnw, dev, reg, wdat) → (cmd, dat, is_last, has_stop). Keeps the step table out of the FSM.

Test Plan:
- Write dev=0x50 reg=0x10 wdat=0xA5, slave ACKs all → strobes seen in order: 0x00, 0x09/0xA0, 0x08/0x10, 0x0A/0xA5; bus shows START, 0xA0, 0x10, 0xA5, STOP; rsp_err=0, one rsp_vld pulse.
- Read dev=0x50 reg=0x10, slave returns 0x3C → strobes 0x00, 0x09/0xA0, 0x08/0x10, 0x09/0xA1, 0x16; bus shows repeated START before 0xA1 and master NACK then STOP on the data byte; rsp_rdat=0x3C, rsp_err=0.
- Device 0x51 absent (address NACK) → no S1 strobe; a STOP-only strobe 0x02 follows; STOP on bus; rsp_err=1.
- A second master forces SDA low during the address byte on attempt 1, bus clean on attempt 2, RETRIES=2 → CLR and S0 reissued once; rsp_err=0. With arbitration lost every attempt → exactly 3 S0 strobes, then rsp_err=2.
- Request held from reset release while the master's init BSY=1 → no m_ws until BSY=0; first strobe is the clear (0x00).
- rst pulsed mid-S1 → next cycle: m_ws=0, req_rdy=0, rsp_vld never pulses; after release req_rdy=1 and a new write completes with rsp_err=0.
